controller: RTL

CONTROLLER -- requirements
Module: controller

---
 rtl/controller.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/controller.sv
// Controller for the eight-phase accumulator CPU. The package holds the opcode
// and phase encodings shared with the rest of the CPU. The controller steps
// through one phase per clock, parks in OP_ADDR on HLT, and decodes the control
// strobes combinationally from the current phase, opcode and zero flag.

package controller_pkg;

    typedef enum logic [2:0] {
        HLT = 3'b000,
        SKZ = 3'b001,
        ADD = 3'b010,
        AND = 3'b011,
        XOR = 3'b100,
        LDA = 3'b101,
        STO = 3'b110,
        JMP = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } state_t;

endpackage

module controller
    import controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst_,
    input  opcode_t     opcode,
    input  logic        zero,
    output logic        mem_rd,
    output logic        load_ir,
    output logic        halt,
    output logic        inc_pc,
    output logic        load_ac,
    output logic        load_pc,
    output logic        mem_wr,
    output logic [2:0]  phase
);

    state_t r_state;
    state_t w_state_next;

    logic w_aluop;
    logic w_is_hlt;
    logic w_is_skz;
    logic w_is_jmp;
    logic w_is_sto;

    // Opcode class decode; unknown encodings fall to the default and assert nothing.
    always_comb begin
        w_aluop  = 1'b0;
        w_is_hlt = 1'b0;
        w_is_skz = 1'b0;
        w_is_jmp = 1'b0;
        w_is_sto = 1'b0;
        case (opcode)
            ADD, AND, XOR, LDA: w_aluop  = 1'b1;
            HLT:                w_is_hlt = 1'b1;
            SKZ:                w_is_skz = 1'b1;
            JMP:                w_is_jmp = 1'b1;
            STO:                w_is_sto = 1'b1;
            default: begin
                w_aluop  = 1'b0;
                w_is_hlt = 1'b0;
                w_is_skz = 1'b0;
                w_is_jmp = 1'b0;
                w_is_sto = 1'b0;
            end
        endcase
    end

    // Phase register; reset aborts any instruction in flight without waiting for clk.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= INST_ADDR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next phase: step through all eight phases, parking in OP_ADDR on HLT.
    always_comb begin
        w_state_next = INST_ADDR;
        unique case (r_state)
            INST_ADDR:  w_state_next = INST_FETCH;
            INST_FETCH: w_state_next = INST_LOAD;
            INST_LOAD:  w_state_next = IDLE;
            IDLE:       w_state_next = OP_ADDR;
            OP_ADDR:    w_state_next = w_is_hlt ? OP_ADDR : OP_FETCH;
            OP_FETCH:   w_state_next = ALU_OP;
            ALU_OP:     w_state_next = STORE;
            STORE:      w_state_next = INST_ADDR;
            default:    w_state_next = INST_ADDR;
        endcase
    end

    // Control strobes decoded from the current phase; forced low while reset is held.
    always_comb begin
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_wr  = 1'b0;
        phase   = r_state;
        if (rst_) begin
            unique case (r_state)
                INST_ADDR: begin
                end
                INST_FETCH: begin
                    mem_rd = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                OP_ADDR: begin
                    halt   = w_is_hlt;
                    inc_pc = ~w_is_hlt;
                end
                OP_FETCH: begin
                    mem_rd = w_aluop;
                end
                ALU_OP: begin
                    mem_rd  = w_aluop;
                    inc_pc  = w_is_skz & zero;
                    load_ac = w_aluop;
                    load_pc = w_is_jmp;
                end
                STORE: begin
                    mem_rd  = w_aluop;
                    inc_pc  = w_is_jmp;
                    load_ac = w_aluop;
                    load_pc = w_is_jmp;
                    mem_wr  = w_is_sto;
                end
                default: begin
                end
            endcase
        end else begin
            phase = 3'd0;
        end
    end

endmodule
